// File: rtl/mdu_pkg.sv
// Shared ALU opcode constants and mul/div decode helpers.
// Imported by the execute-stage multiply/divide unit and its divider.
package mdu_pkg;

  localparam int XLEN      = 32;
  localparam int DIV_STEPS = 32;

  localparam logic [4:0] ALU_ADD           = 5'd0;
  localparam logic [4:0] ALU_SUB           = 5'd1;
  localparam logic [4:0] ALU_AND           = 5'd2;
  localparam logic [4:0] ALU_OR            = 5'd3;
  localparam logic [4:0] ALU_XOR           = 5'd4;
  localparam logic [4:0] ALU_SLT           = 5'd5;
  localparam logic [4:0] ALU_SIGNED_MULT   = 5'd16;
  localparam logic [4:0] ALU_UNSIGNED_MULT = 5'd17;
  localparam logic [4:0] ALU_SIGNED_DIV    = 5'd18;
  localparam logic [4:0] ALU_UNSIGNED_DIV  = 5'd19;

  typedef struct packed {
    logic is_mul;
    logic is_div;
    logic is_signed;
  } md_op_t;

  function automatic md_op_t decode_op(
    input logic [4:0] code
  );
    md_op_t op;
    op = '0;
    unique case (1'b1)
      (code == ALU_SIGNED_MULT): begin
        op.is_mul    = 1'b1;
        op.is_signed = 1'b1;
      end
      (code == ALU_UNSIGNED_MULT): begin
        op.is_mul = 1'b1;
      end
      (code == ALU_SIGNED_DIV): begin
        op.is_div    = 1'b1;
        op.is_signed = 1'b1;
      end
      (code == ALU_UNSIGNED_DIV): begin
        op.is_div = 1'b1;
      end
      default: op = '0;
    endcase
    return op;
  endfunction

  function automatic logic [XLEN-1:0] mag32(
    input logic [XLEN-1:0] x,
    input logic            sgn
  );
    return (sgn && x[XLEN-1]) ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/div_radix2.sv
// Radix-2 restoring divider on unsigned magnitudes, one bit per cycle.
// quot_o/rem_o carry the step result; they are final while done_o is high.
module div_radix2
  import mdu_pkg::*;
(
  input  logic            clk,
  input  logic            resetn,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            done_o,
  output logic [XLEN-1:0] quot_o,
  output logic [XLEN-1:0] rem_o
);

  localparam logic [4:0] LAST = 5'(DIV_STEPS - 1);

  logic [4:0]      cnt_q, cnt_d;
  logic            act_q, act_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quot_q, quot_d;
  logic [XLEN-1:0] dvs_q, dvs_d;

  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic            fits;
  logic [XLEN-1:0] rem_step;
  logic [XLEN-1:0] quot_step;

  always_comb begin
    shifted   = {rem_q, quot_q[XLEN-1]};
    diff      = shifted - {1'b0, dvs_q};
    fits      = ~diff[XLEN];
    rem_step  = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quot_step = {quot_q[XLEN-2:0], fits};
    done_o    = act_q && (cnt_q == LAST);
    quot_o    = quot_step;
    rem_o     = rem_step;
  end

  always_comb begin
    cnt_d  = cnt_q;
    act_d  = act_q;
    rem_d  = rem_q;
    quot_d = quot_q;
    dvs_d  = dvs_q;
    if (abort_i) begin
      act_d = 1'b0;
      cnt_d = '0;
    end else if (start_i) begin
      act_d  = 1'b1;
      cnt_d  = '0;
      rem_d  = '0;
      quot_d = dividend_i;
      dvs_d  = divisor_i;
    end else if (act_q) begin
      rem_d  = rem_step;
      quot_d = quot_step;
      cnt_d  = cnt_q + 5'd1;
      if (done_o) begin
        act_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q  <= '0;
      act_q  <= 1'b0;
      rem_q  <= '0;
      quot_q <= '0;
      dvs_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      rem_q  <= rem_d;
      quot_q <= quot_d;
      dvs_q  <= dvs_d;
    end
  end

endmodule

// File: rtl/mdu.sv
// Execute-stage multiply/divide unit: one-cycle multiply, 32-cycle divide.
// Owns the control FSM, operand latches, multiplier and sign correction.
module mdu
  import mdu_pkg::*;
(
  input  logic            clk,
  input  logic            resetn,
  input  logic [4:0]      alu_controlE,
  input  logic            validE,
  input  logic            flushE,
  input  logic [XLEN-1:0] src_aE,
  input  logic [XLEN-1:0] src_bE,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] hi_out,
  output logic [XLEN-1:0] lo_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic            sgn_q, sgn_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;

  md_op_t          op;
  logic            start;
  logic [63:0]     ext_a;
  logic [63:0]     ext_b;
  logic [63:0]     prod;
  logic            q_neg;
  logic            r_neg;

  logic            div_start;
  logic            div_abort;
  logic            div_done;
  logic [XLEN-1:0] div_quot;
  logic [XLEN-1:0] div_rem;

  always_comb begin
    op        = decode_op(alu_controlE);
    start     = validE & ~flushE & (op.is_mul | op.is_div)
              & (state_q == S_IDLE);
    div_start = start & op.is_div;
    ext_a     = {{32{sgn_q & a_q[XLEN-1]}}, a_q};
    ext_b     = {{32{sgn_q & b_q[XLEN-1]}}, b_q};
    prod      = ext_a * ext_b;
    q_neg     = sgn_q & (a_q[XLEN-1] ^ b_q[XLEN-1]);
    r_neg     = sgn_q & a_q[XLEN-1];
  end

  div_radix2 u_div (
    .clk        (clk),
    .resetn     (resetn),
    .start_i    (div_start),
    .abort_i    (div_abort),
    .dividend_i (mag32(src_aE, op.is_signed)),
    .divisor_i  (mag32(src_bE, op.is_signed)),
    .done_o     (div_done),
    .quot_o     (div_quot),
    .rem_o      (div_rem)
  );

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    sgn_d        = sgn_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    busy         = 1'b0;
    result_valid = 1'b0;
    div_abort    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy = start;
        if (start) begin
          state_d = op.is_mul ? S_MUL : S_DIV;
          a_d     = src_aE;
          b_d     = src_bE;
          sgn_d   = op.is_signed;
        end
      end
      S_MUL: begin
        busy = 1'b1;
        if (flushE) begin
          state_d = S_IDLE;
        end else begin
          state_d      = S_DONE;
          {hi_d, lo_d} = prod;
        end
      end
      S_DIV: begin
        busy = 1'b1;
        if (flushE) begin
          state_d   = S_IDLE;
          div_abort = 1'b1;
        end else if (div_done) begin
          state_d = S_DONE;
          // x/0 returns all-ones quotient and the raw dividend
          if (b_q == '0) begin
            lo_d = '1;
            hi_d = a_q;
          end else begin
            lo_d = q_neg ? -div_quot : div_quot;
            hi_d = r_neg ? -div_rem : div_rem;
          end
        end
      end
      S_DONE: begin
        result_valid = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: driver models issue/flush timing,
// monitor compares busy, result timing and HI/LO every cycle.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [4:0]  alu_controlE = ALU_ADD;
  logic        validE = 1'b0;
  logic        flushE = 1'b0;
  logic [31:0] src_aE = '0;
  logic [31:0] src_bE = '0;
  logic        busy;
  logic        result_valid;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  mdu dut (
    .clk          (clk),
    .resetn       (resetn),
    .alu_controlE (alu_controlE),
    .validE       (validE),
    .flushE       (flushE),
    .src_aE       (src_aE),
    .src_bE       (src_bE),
    .busy         (busy),
    .result_valid (result_valid),
    .hi_out       (hi_out),
    .lo_out       (lo_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;
  bit          exp_busy = 1'b0;
  bit          act_live = 1'b0;
  int          act_t0 = -100;
  int          act_done = -100;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_model(input logic [4:0] code,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, sq, sr;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    if (code == ALU_SIGNED_MULT) return 64'(sa * sb);
    if (code == ALU_UNSIGNED_MULT) return ua * ub;
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (code == ALU_SIGNED_DIV) begin
      sq = sa / sb;
      sr = sa % sb;
      return {sr[31:0], sq[31:0]};
    end
    return {a % b, a / b};
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  function automatic logic [4:0] rnd_code();
    case ($urandom_range(0, 5))
      0: return ALU_SIGNED_MULT;
      1: return ALU_UNSIGNED_MULT;
      2: return ALU_SIGNED_DIV;
      3: return ALU_UNSIGNED_DIV;
      4: return ALU_ADD;
      default: return ALU_SLT;
    endcase
  endfunction

  task automatic step(input bit v, input logic [4:0] code,
                      input logic [31:0] a, input logic [31:0] b,
                      input bit fl);
    bit   md, idle, in_run, st;
    exp_t e;
    @(posedge clk);
    #1;
    validE       = v;
    alu_controlE = code;
    src_aE       = a;
    src_bE       = b;
    flushE       = fl;
    md     = (code == ALU_SIGNED_MULT) || (code == ALU_UNSIGNED_MULT) ||
             (code == ALU_SIGNED_DIV) || (code == ALU_UNSIGNED_DIV);
    idle   = !(act_live && cyc <= act_done);
    in_run = act_live && cyc > act_t0 && cyc < act_done;
    st     = v && !fl && md && idle;
    exp_busy = st || in_run;
    if (in_run && fl) begin
      act_live = 1'b0;
      if (q.size() > 0) q.delete(q.size() - 1);
    end
    if (st) begin
      act_t0   = cyc;
      act_done = cyc + ((code == ALU_SIGNED_MULT ||
                         code == ALU_UNSIGNED_MULT) ? 2 : 33);
      act_live = 1'b1;
      {e.hi, e.lo} = ref_model(code, a, b);
      e.cyc = act_done;
      q.push_back(e);
    end
  endtask

  task automatic idle_n(input int n, input bit fl_last = 1'b0);
    for (int i = 0; i < n; i++)
      step(1'b0, ALU_ADD, $urandom, $urandom, fl_last && (i == n - 1));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    resetn   = 1'b0;
    validE   = 1'b0;
    flushE   = 1'b0;
    exp_busy = 1'b0;
    act_live = 1'b0;
    q.delete();
    last_hi  = '0;
    last_lo  = '0;
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_valid", 64'(result_valid), 64'(0));
    chk("rst_hi", 64'(hi_out), 64'(0));
    chk("rst_lo", 64'(lo_out), 64'(0));
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mon_en && resetn) begin
      chk("busy", 64'(busy), 64'(exp_busy));
      if (result_valid) begin
        if (q.size() == 0) begin
          chk("spurious_valid", 64'(result_valid), 64'(0));
        end else begin
          chk("valid_cycle", 64'(cyc), 64'(q[0].cyc));
          chk("hi", 64'(hi_out), 64'(q[0].hi));
          chk("lo", 64'(lo_out), 64'(q[0].lo));
          last_hi = q[0].hi;
          last_lo = q[0].lo;
          q.delete(0);
        end
      end else begin
        chk("hold_hi", 64'(hi_out), 64'(last_hi));
        chk("hold_lo", 64'(lo_out), 64'(last_lo));
        if (q.size() > 0 && q[0].cyc < cyc) begin
          chk("missing_valid", 64'(result_valid), 64'(1));
          q.delete(0);
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("init_busy", 64'(busy), 64'(0));
    chk("init_valid", 64'(result_valid), 64'(0));
    chk("init_hi", 64'(hi_out), 64'(0));
    chk("init_lo", 64'(lo_out), 64'(0));
    resetn = 1'b1;
    mon_en = 1'b1;

    step(1'b1, ALU_SIGNED_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    idle_n(3);
    step(1'b1, ALU_UNSIGNED_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    idle_n(3);
    step(1'b1, ALU_SIGNED_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    idle_n(34);
    step(1'b1, ALU_SIGNED_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle_n(34);
    step(1'b1, ALU_UNSIGNED_DIV, 32'd100, 32'd0, 1'b0);
    idle_n(34);
    step(1'b1, ALU_SIGNED_DIV, 32'hFFFF_FFFB, 32'd0, 1'b0);
    idle_n(34);

    // divide flushed at T10, then quiet to T40
    step(1'b1, ALU_UNSIGNED_DIV, 32'd12345, 32'd7, 1'b0);
    idle_n(10, 1'b1);
    idle_n(30);
    // divide flushed at T10, multiply issued at T11
    step(1'b1, ALU_SIGNED_DIV, 32'd999, 32'd5, 1'b0);
    idle_n(10, 1'b1);
    step(1'b1, ALU_SIGNED_MULT, 32'h1234_5678, 32'hFFFF_0001, 1'b0);
    idle_n(30);

    // flush beats valid in idle; flush in MUL aborts; flush in DONE is late
    step(1'b1, ALU_SIGNED_MULT, 32'd7, 32'd9, 1'b1);
    idle_n(2);
    step(1'b1, ALU_UNSIGNED_MULT, 32'd11, 32'd13, 1'b0);
    idle_n(1, 1'b1);
    idle_n(3);
    step(1'b1, ALU_UNSIGNED_MULT, 32'd21, 32'd23, 1'b0);
    idle_n(1);
    idle_n(1, 1'b1);
    idle_n(2);

    // back-to-back: new start on the first IDLE cycle after DONE
    step(1'b1, ALU_SIGNED_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    step(1'b1, ALU_UNSIGNED_MULT, 32'd1, 32'd2, 1'b0);
    step(1'b1, ALU_UNSIGNED_MULT, 32'd3, 32'd4, 1'b0);
    step(1'b1, ALU_SIGNED_DIV, 32'hFFFF_FF00, 32'd16, 1'b0);
    idle_n(4);

    // reset in the middle of a divide, then restart immediately
    step(1'b1, ALU_UNSIGNED_DIV, 32'hDEAD_BEEF, 32'd3, 1'b0);
    idle_n(4);
    do_reset();
    step(1'b1, ALU_SIGNED_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    idle_n(40);

    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 3) == 0, rnd_code(), rnd_val(), rnd_val(),
           $urandom_range(0, 19) == 0);
    idle_n(40);
    chk("drain_empty", 64'(q.size()), 64'(0));

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 resetn  input  1  asynchronous, active-low reset; one clock domain only.
REQ-003 alu_controlE  input  5  execute-stage ALU code. Acts only on ALU_SIGNED_MULT, ALU_UNSIGNED_MULT, ALU_SIGNED_DIV and ALU_UNSIGNED_DIV; all other codes are ignored.
REQ-004 validE  input  1  instruction in E is valid and issuing this cycle.
REQ-005 flushE  input  1  cancels any E-stage or in-flight operation.
REQ-006 src_aE  input  32  multiplicand / dividend (rs).
REQ-007 src_bE  input  32  multiplier / divisor (rt).
REQ-008 busy  output  1  pipeline stall request.
REQ-009 result_valid  output  1  one-cycle pulse; HI/LO write enable.
REQ-010 hi_out  output  32  high product word / remainder.
REQ-011 lo_out  output  32  low product word / quotient.

Function
REQ-012 start = validE & ~flushE & (alu_controlE is a mul/div code) & (state==IDLE); start SHALL be ignored in every other state.
REQ-013 States SHALL be IDLE, MUL, DIV, DONE.
- IDLE->MUL on a mult start.
- IDLE->DIV on a div start.
- MUL->DONE after 1 cycle.
- DIV->DONE after 32 iteration cycles.
- DONE->IDLE unconditionally.
REQ-014 On start, operands and the signed/unsigned flag SHALL be latched. Later changes to src_*E SHALL have no effect.
REQ-015 Multiply: the full 64-bit product SHALL be registered in MUL; {hi_out,lo_out}=product. Signed uses two's-complement operands. Latency: start at T0, result_valid at T2.
REQ-016 Divide SHALL be radix-2 restoring on operand magnitudes, one quotient bit per cycle. Start at T0, result_valid at T33.
REQ-017 Signed divide sign rules:
- Quotient is negated when operand signs differ.
- Remainder takes the sign of the dividend.
- 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-018 Divide by zero (either signedness) SHALL give lo=0xFFFFFFFF and hi=the dividend unchanged, at the normal T33 latency.
REQ-019 busy SHALL be 1 in the start cycle (combinational from the inputs) and in every MUL/DIV cycle. It SHALL be 0 in IDLE without a start and 0 in DONE.
REQ-020 result_valid SHALL be 1 only in DONE, for exactly one cycle per completed operation.
REQ-021 hi_out/lo_out SHALL hold their last result until the next DONE.
REQ-022 flushE in MUL or DIV SHALL abort: next state IDLE, busy=0 in the following cycle, no result_valid, hi_out/lo_out unchanged.
REQ-023 flushE in DONE SHALL NOT suppress the result_valid pulse, because the op has already committed.
REQ-024 flushE together with validE in IDLE: flush wins and no operation starts.
REQ-025 A new start SHALL be accepted in the first IDLE cycle after DONE. Minimum spacing between starts is therefore latency+1 cycles.

Reset
REQ-026 resetn low SHALL asynchronously force: state=IDLE, iteration counter=0, busy=0, result_valid=0, hi_out=0, lo_out=0.
REQ-027 Reset asserted mid-operation SHALL discard the operation; no result_valid SHALL follow deassertion.
REQ-028 Reset deassertion SHALL take effect on the next clk edge. The first start SHALL be accepted in the first cycle after release.

Structure
REQ-029 ALU code constants SHALL come from the shared ALU defines header; mdu SHALL NOT redefine them.
REQ-030 State encodings SHALL be local to mdu.
REQ-031 The iterative magnitude divider SHALL be a sub-module div_radix2, which owns the counter, partial remainder and quotient registers and has a start/abort/done interface.
REQ-032 Sign correction and the multiplier SHALL reside in mdu.

Verification
REQ-033 SIGNED_MULT, a=0xFFFFFFFE (-2), b=3: result_valid at T2; hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy high at T0 and T1.
REQ-034 UNSIGNED_MULT, a=b=0xFFFFFFFF: hi=0xFFFFFFFE, lo=0x00000001.
REQ-035 SIGNED_DIV, a=-7 (0xFFFFFFF9), b=2: result_valid at T33; lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also 0x80000000 / -1: lo=0x80000000, hi=0.
REQ-036 UNSIGNED_DIV, a=100, b=0: lo=0xFFFFFFFF, hi=100 at T33.
REQ-037 DIV started, flushE at T10: busy=0 from T11, no result_valid through T40, hi/lo keep prior values. A new MULT issued at T11 completes at T13.
REQ-038 resetn pulsed low at T5 of a DIV: all outputs 0 immediately; no result_valid afterwards; a start at the first post-reset cycle completes normally.
